// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: one instance per requester.
// The requester (CPU load/store unit or DMA/debug master) drives the request
// fields; the arbiter returns the grant and the registered read data.
interface data_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          REQ;     // access request
  logic          WE;      // 1 = write, 0 = read
  logic          LOCK;    // keep ownership for the next cycle too
  logic [AW-1:0] ADDR;
  logic [DW-1:0] WDATA;
  logic          GNT;     // access performed this cycle
  logic [DW-1:0] RDATA;   // registered read data
  logic          RVALID;  // RDATA valid, one-cycle pulse

  modport master (
    output REQ, WE, LOCK, ADDR, WDATA,
    input  GNT, RDATA, RVALID
  );

  modport slave (
    input  REQ, WE, LOCK, ADDR, WDATA,
    output GNT, RDATA, RVALID
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the CPU load/store unit and a
// DMA/debug master. The CPU has fixed priority. The DMA is force-granted after
// STARVE_MAX denied cycles. Either side may lock the bus for atomic
// read-modify-write sequences, bounded to LOCK_MAX consecutive cycles.
// Read data is captured from the combinational memory output at the end of
// the grant cycle and returned with a one-cycle RVALID pulse.
//
// Optional feature: define DATA_MEM_ARB_RANGE_CHECK_EN to block accesses
// above MEM_TOP. Blocked accesses are still granted, but never reach the
// memory. They raise ERR for one cycle, and blocked reads return 16'hDEAD.
module data_mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
  // Only exists when the range check is built in, so the default build has
  // no dangling parameter.
  , parameter logic [AW-1:0] MEM_TOP = 'h1000
`endif
) (
  input  logic              CLK,
  input  logic              RST_N,
  data_mem_arbiter_if.slave cpu_port,
  data_mem_arbiter_if.slave dma_port,
  output logic [AW-1:0]     DMAW,
  output logic [AW-1:0]     DMAR,
  output logic [DW-1:0]     WD,
  output logic              DMS,
  output logic              WRV,
  output logic              RDV,
  input  logic [DW-1:0]     RD,
  output logic              ERR
);

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);
  localparam logic [3:0] LOCK_MAX_C   = 4'(LOCK_MAX);

  // Previous-cycle winner.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } owner_e;

  owner_e        state_q, state_d;
  logic          locked_q, locked_d;          // winner had LOCK high when granted
  logic [3:0]    lock_cnt_q, lock_cnt_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;

  logic          grant_c, grant_d, granted;
  logic          owner_req, other_req;
  logic          w_we, w_lock;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          addr_fault;
  logic [DW-1:0] rd_word;

  logic [DW-1:0] c_rdata_q, d_rdata_q;
  logic          c_rvalid_q, d_rvalid_q;

  // Grant decision: a live lock first, then the expired-lock handover, then
  // CPU priority with the DMA starvation override.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant_c   = 1'b0;
    grant_d   = 1'b0;
    owner_req = 1'b0;
    other_req = 1'b0;
    case (state_q)
      ST_CPU: begin
        owner_req = cpu_port.REQ;
        other_req = dma_port.REQ;
      end
      ST_DMA: begin
        owner_req = dma_port.REQ;
        other_req = cpu_port.REQ;
      end
      default: ;
    endcase
    // Reset forces both grants low so that no strobe reaches the memory.
    if (RST_N) begin
      if (locked_q && owner_req && (lock_cnt_q < LOCK_MAX_C)) begin
        grant_c = (state_q == ST_CPU);
        grant_d = (state_q == ST_DMA);
      end else if (locked_q && owner_req && other_req) begin
        // Lock has reached LOCK_MAX: hand one arbitration to the other side.
        grant_c = (state_q == ST_DMA);
        grant_d = (state_q == ST_CPU);
      end else if (cpu_port.REQ && dma_port.REQ) begin
        grant_d = (starve_cnt_q == STARVE_MAX_C);
        grant_c = !grant_d;
      end else begin
        grant_c = cpu_port.REQ;
        grant_d = dma_port.REQ;
      end
    end
  end

  // Route the granted requester's access fields.
  always_comb begin
    w_we    = 1'b0;
    w_lock  = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    if (grant_c) begin
      w_we    = cpu_port.WE;
      w_lock  = cpu_port.LOCK;
      w_addr  = cpu_port.ADDR;
      w_wdata = cpu_port.WDATA;
    end else if (grant_d) begin
      w_we    = dma_port.WE;
      w_lock  = dma_port.LOCK;
      w_addr  = dma_port.ADDR;
      w_wdata = dma_port.WDATA;
    end
  end

  assign granted = grant_c | grant_d;

`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
  assign addr_fault = granted && (w_addr > MEM_TOP);
`else
  assign addr_fault = 1'b0;
`endif

  // Memory drive. A blocked access keeps its grant but strobes nothing.
  assign DMAW    = w_addr;
  assign DMAR    = w_addr;
  assign WD      = w_wdata;
  assign DMS     = granted & ~addr_fault;
  assign WRV     = DMS & w_we;
  assign RDV     = DMS & ~w_we;
  assign rd_word = addr_fault ? DW'(16'hDEAD) : RD;

  // Next owner, lock tracking and DMA starvation counting.
  always_comb begin
    state_d      = ST_IDLE;
    locked_d     = 1'b0;
    lock_cnt_d   = 4'd0;
    starve_cnt_d = 4'd0;
    if (grant_c)      state_d = ST_CPU;
    else if (grant_d) state_d = ST_DMA;
    locked_d = granted & w_lock;
    if (granted && w_lock) begin
      if (locked_q && (state_d == state_q))
        lock_cnt_d = (lock_cnt_q == 4'hF) ? lock_cnt_q : lock_cnt_q + 4'd1;
      else
        lock_cnt_d = 4'd1;
    end
    if (dma_port.REQ && !grant_d)
      starve_cnt_d = (starve_cnt_q >= STARVE_MAX_C) ? STARVE_MAX_C
                                                     : starve_cnt_q + 4'd1;
  end

  // Owner, lock and starvation registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      locked_q     <= 1'b0;
      lock_cnt_q   <= 4'd0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      locked_q     <= locked_d;
      lock_cnt_q   <= lock_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Read return: capture the memory word into the winner's RDATA register.
  // The loser's register keeps its previous value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      c_rvalid_q <= grant_c & ~w_we;
      d_rvalid_q <= grant_d & ~w_we;
      if (grant_c && !w_we) c_rdata_q <= rd_word;
      if (grant_d && !w_we) d_rdata_q <= rd_word;
    end
  end

`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
  logic err_q;

  // Address fault pulse, one cycle after the offending grant.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_q <= 1'b0;
    else        err_q <= addr_fault;
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign cpu_port.GNT    = grant_c;
  assign cpu_port.RDATA  = c_rdata_q;
  assign cpu_port.RVALID = c_rvalid_q;
  assign dma_port.GNT    = grant_d;
  assign dma_port.RDATA  = d_rdata_q;
  assign dma_port.RVALID = d_rvalid_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter (STARVE_MAX=4, LOCK_MAX=8) with a
// small behavioural memory. Inputs change on the falling edge. Outputs are
// sampled 1 ns later.
module tb_data_mem_arbiter;

  logic        CLK;
  logic        RST_N;
  logic [15:0] DMAW, DMAR, WD, RD;
  logic        DMS, WRV, RDV, ERR;
  logic [15:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  data_mem_arbiter_if #(.AW(16), .DW(16)) c_if ();
  data_mem_arbiter_if #(.AW(16), .DW(16)) d_if ();

  data_mem_arbiter dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .cpu_port (c_if),
    .dma_port (d_if),
    .DMAW     (DMAW),
    .DMAR     (DMAR),
    .WD       (WD),
    .DMS      (DMS),
    .WRV      (WRV),
    .RDV      (RDV),
    .RD       (RD),
    .ERR      (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: combinational read, write committed on the rising edge.
  assign RD = mem[DMAR[7:0]];
  always @(posedge CLK) if (DMS && WRV) mem[DMAW[7:0]] <= WD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of requests at the falling edge, then settle 1 ns.
  task automatic drive(input logic cr, input logic cw, input logic cl,
                       input logic [15:0] ca, input logic [15:0] cd,
                       input logic dr, input logic dw, input logic dl,
                       input logic [15:0] da, input logic [15:0] dd);
    @(negedge CLK);
    c_if.REQ = cr; c_if.WE = cw; c_if.LOCK = cl; c_if.ADDR = ca; c_if.WDATA = cd;
    d_if.REQ = dr; d_if.WE = dw; d_if.LOCK = dl; d_if.ADDR = da; d_if.WDATA = dd;
    #1;
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    logic exp_d, prev_d;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    RST_N = 1'b0;

    // Reset: requests present but nothing may be granted.
    drive(1, 0, 0, 16'h0010, 16'h0, 1, 1, 0, 16'h0020, 16'h1111);
    check("rst_c_gnt", c_if.GNT, 0);
    check("rst_d_gnt", d_if.GNT, 0);
    check("rst_dms", DMS, 0);
    check("rst_wrv", WRV, 0);
    check("rst_rdv", RDV, 0);
    check("rst_c_rvalid", c_if.RVALID, 0);
    check("rst_c_rdata", c_if.RDATA, 0);
    check("rst_d_rvalid", d_if.RVALID, 0);
    check("rst_err", ERR, 0);
    drive_idle();
    RST_N = 1'b1;

    // CPU write then read of 0x0010.
    drive(1, 1, 0, 16'h0010, 16'hA5A5, 0, 0, 0, 16'h0, 16'h0);
    check("wr_c_gnt", c_if.GNT, 1);
    check("wr_d_gnt", d_if.GNT, 0);
    check("wr_dms", DMS, 1);
    check("wr_wrv", WRV, 1);
    check("wr_rdv", RDV, 0);
    check("wr_dmaw", DMAW, 16'h0010);
    check("wr_wd", WD, 16'hA5A5);
    drive(1, 0, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    check("rd_c_gnt", c_if.GNT, 1);
    check("rd_rdv", RDV, 1);
    check("rd_wrv", WRV, 0);
    check("rd_dmar", DMAR, 16'h0010);
    check("rd_no_rvalid_after_write", c_if.RVALID, 0);
    drive_idle();
    check("rd_rvalid", c_if.RVALID, 1);
    check("rd_rdata", c_if.RDATA, 16'hA5A5);
    check("idle_dms", DMS, 0);
    check("idle_dmaw", DMAW, 16'h0000);

    // DMA write alone, then back-to-back CPU reads.
    drive(0, 0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h0020, 16'h1234);
    check("dwr_d_gnt", d_if.GNT, 1);
    check("dwr_c_gnt", c_if.GNT, 0);
    check("dwr_wd", WD, 16'h1234);
    check("rvalid_pulse_end", c_if.RVALID, 0);
    drive(1, 0, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    drive(1, 0, 0, 16'h0020, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    check("b2b_rvalid1", c_if.RVALID, 1);
    check("b2b_rdata1", c_if.RDATA, 16'hA5A5);
    drive_idle();
    check("b2b_rvalid2", c_if.RVALID, 1);
    check("b2b_rdata2", c_if.RDATA, 16'h1234);
    check("b2b_d_rvalid", d_if.RVALID, 0);
    check("b2b_d_rdata", d_if.RDATA, 16'h0000);

    // Both requesting: CPU four cycles, DMA on the fifth, repeating.
    prev_d = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 16'h0010, 16'h0, 1, 0, 0, 16'h0020, 16'h0);
      exp_d = (i % 5 == 4);
      check($sformatf("starve_c_gnt_%0d", i), c_if.GNT, !exp_d);
      check($sformatf("starve_d_gnt_%0d", i), d_if.GNT, exp_d);
      check($sformatf("starve_d_rvalid_%0d", i), d_if.RVALID, prev_d);
      if (prev_d) check($sformatf("starve_d_rdata_%0d", i), d_if.RDATA, 16'h1234);
      prev_d = exp_d;
    end
    drive_idle();
    check("starve_d_rvalid_tail", d_if.RVALID, 1);

    // DMA read-modify-write under lock while the CPU keeps requesting.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 16'h0010, 16'h0, 1, 0, 0, 16'h0020, 16'h0);
      check($sformatf("rmw_pre_c_gnt_%0d", i), c_if.GNT, 1);
    end
    drive(1, 0, 0, 16'h0010, 16'h0, 1, 0, 1, 16'h0020, 16'h0);
    check("rmw_rd_d_gnt", d_if.GNT, 1);
    check("rmw_rd_c_gnt", c_if.GNT, 0);
    drive(1, 0, 0, 16'h0010, 16'h0, 1, 1, 0, 16'h0020, 16'h1235);
    check("rmw_wr_d_gnt", d_if.GNT, 1);
    check("rmw_wr_c_gnt", c_if.GNT, 0);
    check("rmw_wr_wrv", WRV, 1);
    check("rmw_wr_wd", WD, 16'h1235);
    check("rmw_d_rvalid", d_if.RVALID, 1);
    check("rmw_d_rdata", d_if.RDATA, 16'h1234);
    drive(1, 0, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    check("rmw_release_c_gnt", c_if.GNT, 1);
    check("rmw_release_d_gnt", d_if.GNT, 0);
    drive(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0020, 16'h0);
    check("rmw_verify_d_gnt", d_if.GNT, 1);
    drive_idle();
    check("rmw_verify_rdata", d_if.RDATA, 16'h1235);

    // CPU lock held with DMA requesting: DMA wins cycles 9 and 18 only.
    for (int n = 1; n <= 20; n++) begin
      drive(1, 0, 1, 16'h0010, 16'h0, 1, 0, 0, 16'h0020, 16'h0);
      exp_d = (n == 9) || (n == 18);
      check($sformatf("lock_c_gnt_%0d", n), c_if.GNT, !exp_d);
      check($sformatf("lock_d_gnt_%0d", n), d_if.GNT, exp_d);
    end
    drive_idle();

    // Reset during an access: a pending RVALID and an uncommitted write are lost.
    drive(1, 0, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    check("mid_rd_c_gnt", c_if.GNT, 1);
    drive(1, 1, 0, 16'h0030, 16'hBEEF, 0, 0, 0, 16'h0, 16'h0);
    check("mid_rvalid_before", c_if.RVALID, 1);
    check("mid_wr_c_gnt", c_if.GNT, 1);
    #1 RST_N = 1'b0;
    #1;
    check("mid_rst_c_rvalid", c_if.RVALID, 0);
    check("mid_rst_c_rdata", c_if.RDATA, 16'h0000);
    check("mid_rst_d_rdata", d_if.RDATA, 16'h0000);
    check("mid_rst_c_gnt", c_if.GNT, 0);
    check("mid_rst_dms", DMS, 0);
    check("mid_rst_wrv", WRV, 0);
    check("mid_rst_rdv", RDV, 0);
    drive(1, 0, 0, 16'h0030, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    RST_N = 1'b1;
    #1;
    check("post_rst_c_gnt", c_if.GNT, 1);
    check("post_rst_rdv", RDV, 1);
    drive_idle();
    check("post_rst_rvalid", c_if.RVALID, 1);
    check("post_rst_lost_write", c_if.RDATA, 16'h0000);

`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
    // Out-of-range DMA accesses are granted but blocked.
    drive(0, 0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h2000, 16'h7777);
    check("oor_wr_d_gnt", d_if.GNT, 1);
    check("oor_wr_wrv", WRV, 0);
    check("oor_wr_dms", DMS, 0);
    check("oor_wr_err_now", ERR, 0);
    drive_idle();
    check("oor_wr_err_next", ERR, 1);
    check("oor_mem_unchanged", mem[0], 16'h0000);
    drive(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h2000, 16'h0);
    check("oor_rd_d_gnt", d_if.GNT, 1);
    check("oor_rd_rdv", RDV, 0);
    drive_idle();
    check("oor_rd_rvalid", d_if.RVALID, 1);
    check("oor_rd_rdata", d_if.RDATA, 16'hDEAD);
    check("oor_rd_err", ERR, 1);
`else
    // Without the range check, high addresses pass straight through.
    drive(0, 0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h2000, 16'h7777);
    check("hi_wr_d_gnt", d_if.GNT, 1);
    check("hi_wr_wrv", WRV, 1);
    check("hi_wr_dmaw", DMAW, 16'h2000);
    drive_idle();
    check("hi_wr_err", ERR, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
